// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the execute-stage ALU: operation select codes,
// datapath and shift-amount widths, and a helper that tells which codes
// run the shared adder in subtract mode.
//
// Build option: defining ALU_COMB_OUT_EN removes the output registers from
// alu_unit, which makes the ALU outputs purely combinational.
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;

    localparam logic [2:0] ALU_AND  = 3'd0;
    localparam logic [2:0] ALU_OR   = 3'd1;
    localparam logic [2:0] ALU_ADD  = 3'd2;
    localparam logic [2:0] ALU_SLT  = 3'd3;
    localparam logic [2:0] ALU_ADDU = 3'd4;
    localparam logic [2:0] ALU_SLL  = 3'd5;
    localparam logic [2:0] ALU_SUB  = 3'd6;
    localparam logic [2:0] ALU_SLTU = 3'd7;

    // SUB and both set-less-than compares are based on A-B.
    function automatic logic is_sub_op(input logic [2:0] code);
        return (code == ALU_SUB) || (code == ALU_SLT) || (code == ALU_SLTU);
    endfunction

endpackage

// File: rtl/alu_addsub.sv
// ---------------------------------------------------------------------------
// alu_addsub
// Adder/subtractor shared by ADD, ADDU, SUB, SLT and SLTU.
// Subtraction is done as a + ~b + 1, so carry_out is 1 when there is no
// borrow.
//
// Ports:
//   a, b      : operands
//   sub       : 1 = subtract (invert b, carry-in 1), 0 = add
//   sum       : result modulo 2^WIDTH
//   carry_out : carry out of the MSB
//   overflow  : two's-complement overflow of the operation
// ---------------------------------------------------------------------------
module alu_addsub
    import alu_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    logic [WIDTH-1:0] b_eff;

    // Overflow is tested against the effective (possibly inverted) operand.
    // This one expression gives both the add rule and the subtract rule.
    always_comb begin
        b_eff                  = sub ? ~b : b;
        {carry_out, sum}       = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
        overflow               = (a[WIDTH-1] == b_eff[WIDTH-1]) &&
                                 (sum[WIDTH-1] != a[WIDTH-1]);
    end

endmodule

// File: rtl/alu_unit.sv
// ---------------------------------------------------------------------------
// alu_unit
// 32-bit integer ALU for the MIPS execute stage. It supports AND, OR, ADD,
// ADDU, SUB, SLT, SLTU and SLL. Result and flags are registered and have
// one cycle of latency. The reset is asynchronous and active-high.
//
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous active-high reset (R=0, cout=0, ovf=0, ze=1)
//   ctrl   : operation select (alu_pkg ALU_* codes)
//   A, B   : operands
//   shamt  : shift amount, used only by SLL
//   cout   : adder carry-out (ADD/ADDU/SUB only, else 0)
//   ovf    : signed overflow (ADD/SUB only, else 0)
//   ze     : R == 0
//   R      : result
//
// Build option: when ALU_COMB_OUT_EN is defined, the output registers are
// bypassed. The outputs are then combinational, and clk and reset are unused.
// ---------------------------------------------------------------------------
module alu_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         ctrl,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               cout,
    output logic               ovf,
    output logic               ze,
    output logic [WIDTH-1:0]   R
);

    logic [WIDTH-1:0] as_sum;
    logic             as_cout;
    logic             as_ovf;
    logic             as_sub;

    logic [WIDTH-1:0] r_next;
    logic             cout_next;
    logic             ovf_next;
    logic             ze_next;

    assign as_sub = is_sub_op(ctrl);

    alu_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .a         (A),
        .b         (B),
        .sub       (as_sub),
        .sum       (as_sum),
        .carry_out (as_cout),
        .overflow  (as_ovf)
    );

    // Next-state result and flags. Only the arithmetic codes drive the flags.
    // SLT uses sign(A-B) ^ ovf(A-B), so it stays correct when the
    // subtraction overflows. SLTU uses "borrow", which is the inverted carry.
    always_comb begin
        r_next    = '0;
        cout_next = 1'b0;
        ovf_next  = 1'b0;
        case (ctrl)
            ALU_AND:  r_next = A & B;
            ALU_OR:   r_next = A | B;
            ALU_ADD: begin
                r_next    = as_sum;
                cout_next = as_cout;
                ovf_next  = as_ovf;
            end
            ALU_SLT:  r_next = {{(WIDTH-1){1'b0}}, as_sum[WIDTH-1] ^ as_ovf};
            ALU_ADDU: begin
                r_next    = as_sum;
                cout_next = as_cout;
            end
            ALU_SLL:  r_next = A << shamt;
            ALU_SUB: begin
                r_next    = as_sum;
                cout_next = as_cout;
                ovf_next  = as_ovf;
            end
            ALU_SLTU: r_next = {{(WIDTH-1){1'b0}}, ~as_cout};
            default: begin
                r_next    = '0;
                cout_next = 1'b0;
                ovf_next  = 1'b0;
            end
        endcase
        ze_next = (r_next == '0);
    end

`ifdef ALU_COMB_OUT_EN
    // Zero-latency variant: the outputs come directly from the next-state logic.
    assign R    = r_next;
    assign cout = cout_next;
    assign ovf  = ovf_next;
    assign ze   = ze_next;
`else
    // Output register. Reset clears the result, so the zero flag reads 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            R    <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
            ze   <= 1'b1;
        end else begin
            R    <= r_next;
            cout <= cout_next;
            ovf  <= ovf_next;
            ze   <= ze_next;
        end
    end
`endif

endmodule

// File: tb/tb_alu_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_unit
// Directed and randomized checks of alu_unit in its default registered
// form. Each expected result is pushed to a queue when its stimulus is
// driven. It is popped and compared one clock later.
// ---------------------------------------------------------------------------
module tb_alu_unit;

    logic        clk;
    logic        reset;
    logic [2:0]  ctrl;
    logic [31:0] A;
    logic [31:0] B;
    logic [4:0]  shamt;
    logic        cout;
    logic        ovf;
    logic        ze;
    logic [31:0] R;

    typedef struct packed {
        logic [31:0] r;
        logic        c;
        logic        o;
        logic        z;
    } exp_t;

    exp_t expQ[$];
    int   nCompared;
    int   nMismatched;

    alu_unit dut (
        .clk   (clk),
        .reset (reset),
        .ctrl  (ctrl),
        .A     (A),
        .B     (B),
        .shamt (shamt),
        .cout  (cout),
        .ovf   (ovf),
        .ze    (ze),
        .R     (R)
    );

    // Free-running 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference behaviour built from wide arithmetic and the language's
    // signed/unsigned compares rather than from an adder structure.
    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] sh);
        exp_t        e;
        logic [32:0] s;
        longint      sa;
        longint      sb;
        longint      t;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e  = '0;
        case (op)
            3'd0: e.r = a & b;
            3'd1: e.r = a | b;
            3'd2: begin
                s   = {1'b0, a} + {1'b0, b};
                e.r = s[31:0];
                e.c = s[32];
                t   = sa + sb;
                e.o = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            end
            3'd3: e.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd4: begin
                s   = {1'b0, a} + {1'b0, b};
                e.r = s[31:0];
                e.c = s[32];
            end
            3'd5: e.r = a << sh;
            3'd6: begin
                e.r = a - b;
                e.c = (a >= b);
                t   = sa - sb;
                e.o = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            end
            default: e.r = (a < b) ? 32'd1 : 32'd0;
        endcase
        e.z = (e.r == 32'd0);
        return e;
    endfunction

    task automatic checkField(input string tag, input logic [31:0] obs,
                              input logic [31:0] expv);
        nCompared++;
        assert (obs === expv)
        else begin
            nMismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Drive one operation at the falling edge and push its known result.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] sh,
                                 input logic [31:0] er, input logic ec,
                                 input logic eo);
        exp_t e;
        @(negedge clk);
        ctrl  = op;
        A     = a;
        B     = b;
        shamt = sh;
        e.r   = er;
        e.c   = ec;
        e.o   = eo;
        e.z   = (er == 32'd0);
        expQ.push_back(e);
    endtask

    // Let one rising edge capture the result, then compare just after it.
    task automatic checkOutput(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        nCompared++;
        assert (expQ.size() > 0)
        else begin
            nMismatched++;
            $error("[TB] FAIL %s.queue: observed empty expected an entry", tag);
        end
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkField({tag, ".R"},    R,            e.r);
            checkField({tag, ".cout"}, {31'd0, cout}, {31'd0, e.c});
            checkField({tag, ".ovf"},  {31'd0, ovf},  {31'd0, e.o});
            checkField({tag, ".ze"},   {31'd0, ze},   {31'd0, e.z});
        end
    endtask

    initial begin
        exp_t        m;
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [4:0]  rsh;

        nCompared   = 0;
        nMismatched = 0;
        reset = 1'b1;
        ctrl  = 3'd0;
        A     = 32'd0;
        B     = 32'd0;
        shamt = 5'd0;

        // Reset state while reset is held
        #12;
        checkField("rst.R",    R,             32'd0);
        checkField("rst.cout", {31'd0, cout}, 32'd0);
        checkField("rst.ovf",  {31'd0, ovf},  32'd0);
        checkField("rst.ze",   {31'd0, ze},   32'd1);
        @(negedge clk);
        reset = 1'b0;

        applyStimulus(3'd0, 32'hAAAAAAAA, 32'hFFFFFFFF, 5'd0, 32'hAAAAAAAA, 1'b0, 1'b0);
        checkOutput("and");
        applyStimulus(3'd1, 32'h0F0F0000, 32'h0000F0F0, 5'd0, 32'h0F0FF0F0, 1'b0, 1'b0);
        checkOutput("or");
        applyStimulus(3'd2, 32'h40000000, 32'h40000000, 5'd0, 32'h80000000, 1'b0, 1'b1);
        checkOutput("add_posovf");
        applyStimulus(3'd2, 32'h80000000, 32'h80000000, 5'd0, 32'h00000000, 1'b1, 1'b1);
        checkOutput("add_negovf");
        applyStimulus(3'd4, 32'h40000000, 32'h40000000, 5'd0, 32'h80000000, 1'b0, 1'b0);
        checkOutput("addu");
        applyStimulus(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 32'hFFFFFFFE, 1'b1, 1'b0);
        checkOutput("add_m1m1");
        applyStimulus(3'd2, 32'hFFFFFFFF, 32'h00000001, 5'd0, 32'h00000000, 1'b1, 1'b0);
        checkOutput("add_wrap");
        applyStimulus(3'd6, 32'd236, 32'd13698, 5'd0, 32'hFFFFCB6A, 1'b0, 1'b0);
        checkOutput("sub_borrow");
        applyStimulus(3'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 32'h00000000, 1'b1, 1'b0);
        checkOutput("sub_zero");
        applyStimulus(3'd6, 32'h7FFFFFFF, 32'hFFFFFFFF, 5'd0, 32'h80000000, 1'b0, 1'b1);
        checkOutput("sub_ovf");
        applyStimulus(3'd3, 32'h80956829, 32'h60982375, 5'd0, 32'd1, 1'b0, 1'b0);
        checkOutput("slt");
        applyStimulus(3'd7, 32'h80956829, 32'h60982375, 5'd0, 32'd0, 1'b0, 1'b0);
        checkOutput("sltu_ge");
        applyStimulus(3'd7, 32'd5, 32'd1309786, 5'd0, 32'd1, 1'b0, 1'b0);
        checkOutput("sltu_lt");
        applyStimulus(3'd3, 32'h7FFFFFFF, 32'h80000000, 5'd0, 32'd0, 1'b0, 1'b0);
        checkOutput("slt_ovfcase");
        applyStimulus(3'd5, 32'hF0F0F0F0, 32'hFFFFFFFF, 5'd0, 32'hF0F0F0F0, 1'b0, 1'b0);
        checkOutput("sll0");
        applyStimulus(3'd5, 32'hF0F0F0F0, 32'h12345678, 5'd1, 32'hE1E1E1E0, 1'b0, 1'b0);
        checkOutput("sll1");
        applyStimulus(3'd5, 32'hF0F0F0F0, 32'h00000000, 5'd6, 32'h3C3C3C00, 1'b0, 1'b0);
        checkOutput("sll6");

        // Back-to-back operations: push the next expectation before popping.
        applyStimulus(3'd0, 32'h12345678, 32'h0000FFFF, 5'd0, 32'h00005678, 1'b0, 1'b0);
        checkOutput("b2b_and");
        applyStimulus(3'd4, 32'hFFFFFFFF, 32'h00000002, 5'd0, 32'h00000001, 1'b1, 1'b0);
        checkOutput("b2b_addu");

        // Randomized operations against the reference model
        for (int i = 0; i < 24; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = (i % 4 == 0) ? ra : $urandom;
            rsh = 5'($urandom_range(0, 31));
            m   = model(rop, ra, rb, rsh);
            applyStimulus(rop, ra, rb, rsh, m.r, m.c, m.o);
            checkOutput("rand");
        end

        // Assert reset between edges. The outputs must clear without a clock,
        // and the pending operation is dropped.
        applyStimulus(3'd1, 32'hDEAD0000, 32'h0000BEEF, 5'd0, 32'hDEADBEEF, 1'b0, 1'b0);
        checkOutput("pre_rst");
        @(negedge clk);
        ctrl  = 3'd2;
        A     = 32'h80000000;
        B     = 32'h80000000;
        #1;
        reset = 1'b1;
        #1;
        checkField("async_rst.R",    R,             32'd0);
        checkField("async_rst.cout", {31'd0, cout}, 32'd0);
        checkField("async_rst.ovf",  {31'd0, ovf},  32'd0);
        checkField("async_rst.ze",   {31'd0, ze},   32'd1);
        #1;
        reset = 1'b0;
        // The first edge after release captures the inputs now present.
        m = model(3'd2, 32'h80000000, 32'h80000000, 5'd0);
        expQ.push_back(m);
        checkOutput("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
